// File: rtl/reservation_station_pkg.sv
// -----------------------------------------------------------------------------
// reservation_station_pkg
// Shared constants for the arithmetic reservation station, the ALU and the
// dispatcher: datapath widths, reserved "empty" encodings, the internal ALU
// opcode set, the per-entry storage layout and the operand capture helper.
// -----------------------------------------------------------------------------
package reservation_station_pkg;

    localparam int DATA_WIDTH          = 32;
    localparam int ROB_TAG_WIDTH       = 4;
    localparam int INSIDE_OPCODE_WIDTH = 5;

    localparam logic [INSIDE_OPCODE_WIDTH-1:0] NOP          = 5'd0;
    localparam logic [ROB_TAG_WIDTH-1:0]       ZERO_TAG_ROB = '0;
    localparam logic [DATA_WIDTH-1:0]          ZERO_DATA    = '0;

    // Internal ALU opcodes, shared with the ALU decoder and the dispatcher.
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_ADD  = 5'd1;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SUB  = 5'd2;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_AND  = 5'd3;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_OR   = 5'd4;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_XOR  = 5'd5;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLL  = 5'd6;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SRL  = 5'd7;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SRA  = 5'd8;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLT  = 5'd9;
    localparam logic [INSIDE_OPCODE_WIDTH-1:0] OP_SLTU = 5'd10;

    // One source operand: value plus the ROB tag it is still waiting on.
    typedef struct packed {
        logic [DATA_WIDTH-1:0]    value;
        logic [ROB_TAG_WIDTH-1:0] tag;
    } operand_t;

    // Payload of one station entry; the busy bit is kept separately so it
    // alone needs a reset.
    typedef struct packed {
        logic [INSIDE_OPCODE_WIDTH-1:0] op;
        logic [DATA_WIDTH-1:0]          v1;
        logic [ROB_TAG_WIDTH-1:0]       t1;
        logic [DATA_WIDTH-1:0]          v2;
        logic [ROB_TAG_WIDTH-1:0]       t2;
        logic [DATA_WIDTH-1:0]          imm;
        logic [ROB_TAG_WIDTH-1:0]       dest;
    } rs_entry_t;

    // Snoop both result buses for a pending operand. A zero tag never
    // matches, so an idle bus cannot wake anything. The ALU bus wins a tie.
    function automatic operand_t capture_operand(
        input operand_t                 opnd,
        input logic [ROB_TAG_WIDTH-1:0] alu_tag,
        input logic [DATA_WIDTH-1:0]    alu_value,
        input logic [ROB_TAG_WIDTH-1:0] lsb_tag,
        input logic [DATA_WIDTH-1:0]    lsb_value
    );
        operand_t res;
        res = opnd;
        if (opnd.tag != ZERO_TAG_ROB) begin
            if (opnd.tag == alu_tag) begin
                res.value = alu_value;
                res.tag   = ZERO_TAG_ROB;
            end else if (opnd.tag == lsb_tag) begin
                res.value = lsb_value;
                res.tag   = ZERO_TAG_ROB;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_lowest_pick.sv
// -----------------------------------------------------------------------------
// rs_lowest_pick
// Lowest-set-bit priority encoder.
//   req   : request vector, bit 0 has highest priority
//   idx   : index of the lowest set bit (0 when nothing is set)
//   found : at least one request bit is set
// -----------------------------------------------------------------------------
module rs_lowest_pick #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         req,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     found
);

    localparam int IDX_W = $clog2(WIDTH);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// -----------------------------------------------------------------------------
// reservation_station
// Arithmetic reservation station feeding the combinational ALU. Holds decoded
// ALU instructions until both operands are ready, snoops the ALU and LSB result
// broadcasts for wake-up and issues at most one ready entry per cycle through
// registered outputs.
//   clk, rst (async, active low), rdy (global enable), in_flush (sync clear)
//   in_valid/in_op/in_value*/in_tag*/in_imm/in_rob_tag : dispatch port
//   in_alu_cdb_*, in_lsb_cdb_*                         : result broadcasts
//   out_full                                           : every entry busy
//   out_op/out_value*/out_imm/out_rob_tag              : registered issue port
// -----------------------------------------------------------------------------
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic                           in_flush,
    input  logic                           in_valid,
    input  logic [INSIDE_OPCODE_WIDTH-1:0] in_op,
    input  logic [DATA_WIDTH-1:0]          in_value1,
    input  logic [DATA_WIDTH-1:0]          in_value2,
    input  logic [ROB_TAG_WIDTH-1:0]       in_tag1,
    input  logic [ROB_TAG_WIDTH-1:0]       in_tag2,
    input  logic [DATA_WIDTH-1:0]          in_imm,
    input  logic [ROB_TAG_WIDTH-1:0]       in_rob_tag,
    input  logic [ROB_TAG_WIDTH-1:0]       in_alu_cdb_tag,
    input  logic [DATA_WIDTH-1:0]          in_alu_cdb_value,
    input  logic [ROB_TAG_WIDTH-1:0]       in_lsb_cdb_tag,
    input  logic [DATA_WIDTH-1:0]          in_lsb_cdb_value,
    output logic                           out_full,
    output logic [INSIDE_OPCODE_WIDTH-1:0] out_op,
    output logic [DATA_WIDTH-1:0]          out_value1,
    output logic [DATA_WIDTH-1:0]          out_value2,
    output logic [DATA_WIDTH-1:0]          out_imm,
    output logic [ROB_TAG_WIDTH-1:0]       out_rob_tag
);

    localparam int IDX_W = $clog2(DEPTH);

    rs_entry_t                      entry_q [DEPTH];
    rs_entry_t                      entry_d [DEPTH];
    logic [DEPTH-1:0]               busy_q;
    logic [DEPTH-1:0]               busy_d;
    logic [DEPTH-1:0]               ready_vec;

    logic [INSIDE_OPCODE_WIDTH-1:0] out_op_q, out_op_d;
    logic [DATA_WIDTH-1:0]          out_value1_q, out_value1_d;
    logic [DATA_WIDTH-1:0]          out_value2_q, out_value2_d;
    logic [DATA_WIDTH-1:0]          out_imm_q, out_imm_d;
    logic [ROB_TAG_WIDTH-1:0]       out_rob_tag_q, out_rob_tag_d;

    logic [IDX_W-1:0]               free_idx, issue_idx;
    logic                           free_found, issue_found;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = busy_q[i] && (entry_q[i].t1 == ZERO_TAG_ROB)
                                     && (entry_q[i].t2 == ZERO_TAG_ROB);
        end
    end

    assign out_full = &busy_q;

    rs_lowest_pick #(.WIDTH(DEPTH)) u_free_pick (
        .req   (~busy_q),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_lowest_pick #(.WIDTH(DEPTH)) u_issue_pick (
        .req   (ready_vec),
        .idx   (issue_idx),
        .found (issue_found)
    );

    // Next-state logic. Issue and dispatch both look only at pre-edge busy
    // and tag state, so a freshly woken or freshly dispatched entry waits one
    // edge, and the slot freed by issue is not reused until the next cycle.
    // Wake-up only touches busy entries and dispatch only a non-busy one, so
    // the three updates never collide on the same entry.
    always_comb begin
        operand_t opnd;

        entry_d       = entry_q;
        busy_d        = busy_q;
        out_op_d      = NOP;
        out_value1_d  = ZERO_DATA;
        out_value2_d  = ZERO_DATA;
        out_imm_d     = ZERO_DATA;
        out_rob_tag_d = ZERO_TAG_ROB;
        opnd          = '0;

        if (in_flush) begin
            busy_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i]) begin
                    opnd = capture_operand('{value: entry_q[i].v1, tag: entry_q[i].t1},
                                           in_alu_cdb_tag, in_alu_cdb_value,
                                           in_lsb_cdb_tag, in_lsb_cdb_value);
                    entry_d[i].v1 = opnd.value;
                    entry_d[i].t1 = opnd.tag;
                    opnd = capture_operand('{value: entry_q[i].v2, tag: entry_q[i].t2},
                                           in_alu_cdb_tag, in_alu_cdb_value,
                                           in_lsb_cdb_tag, in_lsb_cdb_value);
                    entry_d[i].v2 = opnd.value;
                    entry_d[i].t2 = opnd.tag;
                end
            end

            if (issue_found) begin
                out_op_d          = entry_q[issue_idx].op;
                out_value1_d      = entry_q[issue_idx].v1;
                out_value2_d      = entry_q[issue_idx].v2;
                out_imm_d         = entry_q[issue_idx].imm;
                out_rob_tag_d     = entry_q[issue_idx].dest;
                busy_d[issue_idx] = 1'b0;
            end

            // free_found is the complement of out_full; dispatching while
            // full silently drops the instruction.
            if (in_valid && free_found) begin
                entry_d[free_idx].op   = in_op;
                entry_d[free_idx].imm  = in_imm;
                entry_d[free_idx].dest = in_rob_tag;
                opnd = capture_operand('{value: in_value1, tag: in_tag1},
                                       in_alu_cdb_tag, in_alu_cdb_value,
                                       in_lsb_cdb_tag, in_lsb_cdb_value);
                entry_d[free_idx].v1 = opnd.value;
                entry_d[free_idx].t1 = opnd.tag;
                opnd = capture_operand('{value: in_value2, tag: in_tag2},
                                       in_alu_cdb_tag, in_alu_cdb_value,
                                       in_lsb_cdb_tag, in_lsb_cdb_value);
                entry_d[free_idx].v2 = opnd.value;
                entry_d[free_idx].t2 = opnd.tag;
                busy_d[free_idx]     = 1'b1;
            end
        end
    end

    // Control state and the issue registers are the only things reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q        <= '0;
            out_op_q      <= NOP;
            out_value1_q  <= ZERO_DATA;
            out_value2_q  <= ZERO_DATA;
            out_imm_q     <= ZERO_DATA;
            out_rob_tag_q <= ZERO_TAG_ROB;
        end else if (rdy) begin
            busy_q        <= busy_d;
            out_op_q      <= out_op_d;
            out_value1_q  <= out_value1_d;
            out_value2_q  <= out_value2_d;
            out_imm_q     <= out_imm_d;
            out_rob_tag_q <= out_rob_tag_d;
        end
    end

    // Payload is meaningless while busy is clear, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            entry_q <= entry_d;
        end
    end

    assign out_op      = out_op_q;
    assign out_value1  = out_value1_q;
    assign out_value2  = out_value2_q;
    assign out_imm     = out_imm_q;
    assign out_rob_tag = out_rob_tag_q;

endmodule

// File: tb/tb_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_reservation_station
// Directed bench for the reservation station: reset, ready dispatch, enable
// hold, CDB wake-up, dispatch forwarding, fill plus in-order drain, flush and
// a mid-run reset. Inputs change 1 ns after each rising edge; outputs are
// sampled at the same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic                           clk;
    logic                           rst;
    logic                           rdy;
    logic                           in_flush;
    logic                           in_valid;
    logic [INSIDE_OPCODE_WIDTH-1:0] in_op;
    logic [DATA_WIDTH-1:0]          in_value1, in_value2, in_imm;
    logic [ROB_TAG_WIDTH-1:0]       in_tag1, in_tag2, in_rob_tag;
    logic [ROB_TAG_WIDTH-1:0]       in_alu_cdb_tag, in_lsb_cdb_tag;
    logic [DATA_WIDTH-1:0]          in_alu_cdb_value, in_lsb_cdb_value;
    logic                           out_full;
    logic [INSIDE_OPCODE_WIDTH-1:0] out_op;
    logic [DATA_WIDTH-1:0]          out_value1, out_value2, out_imm;
    logic [ROB_TAG_WIDTH-1:0]       out_rob_tag;

    int assertCount = 0;
    int failCount   = 0;

    reservation_station #(.DEPTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_flush         (in_flush),
        .in_valid         (in_valid),
        .in_op            (in_op),
        .in_value1        (in_value1),
        .in_value2        (in_value2),
        .in_tag1          (in_tag1),
        .in_tag2          (in_tag2),
        .in_imm           (in_imm),
        .in_rob_tag       (in_rob_tag),
        .in_alu_cdb_tag   (in_alu_cdb_tag),
        .in_alu_cdb_value (in_alu_cdb_value),
        .in_lsb_cdb_tag   (in_lsb_cdb_tag),
        .in_lsb_cdb_value (in_lsb_cdb_value),
        .out_full         (out_full),
        .out_op           (out_op),
        .out_value1       (out_value1),
        .out_value2       (out_value2),
        .out_imm          (out_imm),
        .out_rob_tag      (out_rob_tag)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Check a full issue bundle on the output registers.
    task automatic checkIssue(input string tag, input logic [4:0] op,
                              input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] imm, input logic [3:0] dest);
        checkOutput({tag, ".op"},     32'(out_op),      32'(op));
        checkOutput({tag, ".value1"}, out_value1,       v1);
        checkOutput({tag, ".value2"}, out_value2,       v2);
        checkOutput({tag, ".imm"},    out_imm,          imm);
        checkOutput({tag, ".rob"},    32'(out_rob_tag), 32'(dest));
    endtask

    // Check that the output registers show no issue.
    task automatic checkIdle(input string tag);
        checkOutput({tag, ".op"},     32'(out_op),      32'(NOP));
        checkOutput({tag, ".rob"},    32'(out_rob_tag), 32'(ZERO_TAG_ROB));
        checkOutput({tag, ".value1"}, out_value1,       32'h0);
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the dispatch port; dispatching while full is a protocol error.
    task automatic applyStimulus(input logic valid, input logic [4:0] op,
                                 input logic [31:0] v1, input logic [3:0] t1,
                                 input logic [31:0] v2, input logic [3:0] t2,
                                 input logic [31:0] imm, input logic [3:0] dest);
        if (valid) begin
            assertCount++;
            assert (out_full === 1'b0) else begin
                failCount++;
                $error("[TB] FAIL dispatch_while_full: observed out_full %b expected 0", out_full);
            end
        end
        in_valid   = valid;
        in_op      = op;
        in_value1  = v1;
        in_tag1    = t1;
        in_value2  = v2;
        in_tag2    = t2;
        in_imm     = imm;
        in_rob_tag = dest;
    endtask

    task automatic idleStimulus();
        applyStimulus(1'b0, NOP, 32'h0, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0);
    endtask

    task automatic setCdb(input logic [3:0] alu_tag, input logic [31:0] alu_val,
                          input logic [3:0] lsb_tag, input logic [31:0] lsb_val);
        in_alu_cdb_tag   = alu_tag;
        in_alu_cdb_value = alu_val;
        in_lsb_cdb_tag   = lsb_tag;
        in_lsb_cdb_value = lsb_val;
    endtask

    initial begin
        rst      = 1'b0;
        rdy      = 1'b1;
        in_flush = 1'b0;
        idleStimulus();
        setCdb(4'd0, 32'h0, 4'd0, 32'h0);

        // Power-on reset.
        step();
        step();
        checkIdle("reset");
        checkOutput("reset.full", 32'(out_full), 32'h0);
        rst = 1'b1;
        step();

        // Ready dispatch issues one edge later, then goes idle.
        applyStimulus(1'b1, OP_ADD, 32'd5, 4'd0, 32'd7, 4'd0, 32'h11, 4'd3);
        step();
        idleStimulus();
        checkIdle("ready_disp_e0");
        step();
        checkIssue("ready_disp_e1", OP_ADD, 32'd5, 32'd7, 32'h11, 4'd3);
        step();
        checkIdle("ready_disp_e2");

        // With rdy low the dispatch is ignored entirely.
        rdy = 1'b0;
        applyStimulus(1'b1, OP_ADD, 32'd1, 4'd0, 32'd1, 4'd0, 32'h0, 4'd2);
        step();
        step();
        idleStimulus();
        rdy = 1'b1;
        checkIdle("rdy_low");
        step();
        checkIdle("rdy_low_after");

        // Wake-up from the ALU bus after three idle cycles.
        applyStimulus(1'b1, OP_SUB, 32'h0, 4'd4, 32'd2, 4'd0, 32'h77, 4'd5);
        step();
        idleStimulus();
        for (int i = 0; i < 3; i++) begin
            step();
            checkIdle("wake_wait");
        end
        setCdb(4'd4, 32'h1234, 4'd0, 32'h0);
        step();
        setCdb(4'd0, 32'h0, 4'd0, 32'h0);
        checkIdle("wake_capture_edge");
        step();
        checkIssue("wake_issue", OP_SUB, 32'h1234, 32'd2, 32'h77, 4'd5);

        // Dispatch forwarding from the LSB bus in the same cycle.
        applyStimulus(1'b1, OP_AND, 32'd1, 4'd0, 32'h0, 4'd6, 32'h0, 4'd7);
        setCdb(4'd0, 32'h0, 4'd6, 32'd9);
        step();
        idleStimulus();
        setCdb(4'd0, 32'h0, 4'd0, 32'h0);
        step();
        checkIssue("forward_issue", OP_AND, 32'd1, 32'd9, 32'h0, 4'd7);

        // Fill all eight entries waiting on tag 5, then drain in index order.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, OP_XOR, 32'h0, 4'd5, 32'(i), 4'd0, 32'(i + 100), 4'(i + 1));
            step();
        end
        idleStimulus();
        checkOutput("fill.full", 32'(out_full), 32'h1);
        checkIdle("fill_idle");
        setCdb(4'd5, 32'h50, 4'd0, 32'h0);
        step();
        setCdb(4'd0, 32'h0, 4'd0, 32'h0);
        checkOutput("woken.full", 32'(out_full), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step();
            checkIssue("drain", OP_XOR, 32'h50, 32'(i), 32'(i + 100), 4'(i + 1));
            if (i == 0) begin
                checkOutput("drain.full_drop", 32'(out_full), 32'h0);
            end
        end
        step();
        checkIdle("drain_done");

        // Flush with a ready entry pending and a simultaneous dispatch.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_ADD, 32'h0, 4'd9, 32'h0, 4'd0, 32'h0, 4'(i + 1));
            step();
        end
        applyStimulus(1'b1, OP_OR, 32'd3, 4'd0, 32'd4, 4'd0, 32'h0, 4'd4);
        step();
        applyStimulus(1'b1, OP_ADD, 32'd1, 4'd0, 32'd1, 4'd0, 32'h0, 4'd10);
        in_flush = 1'b1;
        step();
        in_flush = 1'b0;
        idleStimulus();
        checkIdle("flush_edge");
        checkOutput("flush.full", 32'(out_full), 32'h0);
        step();
        checkIdle("flush_dropped_dispatch");
        setCdb(4'd9, 32'h99, 4'd0, 32'h0);
        step();
        setCdb(4'd0, 32'h0, 4'd0, 32'h0);
        step();
        checkIdle("flush_no_wake");

        // Reset mid-run: three waiting entries plus one issuing.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_ADD, 32'h0, 4'd11, 32'h0, 4'd0, 32'h0, 4'(i + 1));
            step();
        end
        applyStimulus(1'b1, OP_ADD, 32'd8, 4'd0, 32'd9, 4'd0, 32'h0, 4'd12);
        step();
        idleStimulus();
        step();
        checkIssue("pre_reset_issue", OP_ADD, 32'd8, 32'd9, 32'h0, 4'd12);
        rst = 1'b0;
        #2;
        checkIdle("async_reset");
        checkOutput("async_reset.full", 32'(out_full), 32'h0);
        rst = 1'b1;
        setCdb(4'd11, 32'hAB, 4'd0, 32'h0);
        step();
        setCdb(4'd0, 32'h0, 4'd0, 32'h0);
        checkIdle("post_reset_1");
        step();
        checkIdle("post_reset_2");
        checkOutput("post_reset.full", 32'(out_full), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
